// File: rtl/point_cloud_store.sv
// Point-cloud memory for ransac_logic: a host load stream fills the store, and
// pipelined point fetches return data a fixed number of cycles later.
package ransac_fixed;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } point_t;
endpackage

module point_cloud_store #(
  parameter int max_point_count  = 512,
  parameter int point_addr_width = $clog2(max_point_count),
  parameter int read_latency     = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        lock,
  input  logic                        load_clear,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  ransac_fixed::point_t        load_point,
  input  logic                        load_last,
  output logic                        cloud_ready,
  output logic [point_addr_width-1:0] point_count,
  output logic                        overflow,
  input  logic                        point_addr_valid,
  input  logic [point_addr_width-1:0] point_addr,
  output ransac_fixed::point_t        point_in,
  output logic                        point_data_valid,
  output logic                        point_addr_error
);

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  localparam logic [point_addr_width:0] full_count = (point_addr_width + 1)'(max_point_count);
  localparam logic [point_addr_width:0] last_index = (point_addr_width + 1)'(max_point_count - 1);
  localparam logic [point_addr_width:0] min_cloud  = (point_addr_width + 1)'(3);

  state_t                      state_reg;
  logic [point_addr_width:0]   count_reg;
  logic [point_addr_width-1:0] point_count_reg;
  logic                        overflow_reg;

  ransac_fixed::point_t mem [max_point_count];

  logic [read_latency-1:0] valid_pipe_reg;
  logic [read_latency-1:0] error_pipe_reg;
  ransac_fixed::point_t    data_pipe_reg [read_latency];

  logic clear_now;
  logic accept;
  logic write_en;

  assign clear_now  = load_clear && !lock;
  assign load_ready = (state_reg != READY) && !lock && (count_reg < full_count);
  assign accept     = load_valid && load_ready;
  // A clear wins over a simultaneous accept, so that point never lands in memory.
  assign write_en   = accept && !clear_now;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= EMPTY;
      count_reg       <= '0;
      point_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else if (clear_now) begin
      state_reg       <= EMPTY;
      count_reg       <= '0;
      point_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      if (accept) begin
        count_reg       <= count_reg + 1'b1;
        point_count_reg <= count_reg[point_addr_width-1:0];
        if (load_last || count_reg == last_index)
          state_reg <= READY;
        else
          state_reg <= LOADING;
      end
      if (state_reg == LOADING && load_valid && count_reg == full_count)
        overflow_reg <= 1'b1;
    end
  end

  assign point_count = point_count_reg;
  assign overflow    = overflow_reg;
  assign cloud_ready = (state_reg == READY) && (count_reg >= min_cloud);

  // Memory and data pipeline carry no reset so the array maps onto block RAM.
  always_ff @(posedge clock) begin
    if (write_en)
      mem[count_reg[point_addr_width-1:0]] <= load_point;
    data_pipe_reg[0] <= mem[point_addr];
    for (int i = 1; i < read_latency; i++)
      data_pipe_reg[i] <= data_pipe_reg[i-1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_pipe_reg <= '0;
      error_pipe_reg <= '0;
    end else begin
      valid_pipe_reg[0] <= point_addr_valid;
      error_pipe_reg[0] <= point_addr_valid && ({1'b0, point_addr} >= count_reg);
      for (int i = 1; i < read_latency; i++) begin
        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
        error_pipe_reg[i] <= error_pipe_reg[i-1];
      end
    end
  end

  assign point_data_valid = valid_pipe_reg[read_latency-1];
  assign point_addr_error = error_pipe_reg[read_latency-1];
  assign point_in = (point_data_valid && !point_addr_error) ? data_pipe_reg[read_latency-1] : '0;

endmodule
